// File: rtl/fib_pkg.sv
// Shared types and seed constants for the two-term recurrence generator.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fib_state_e;

  localparam logic MODE_FIB   = 1'b0;
  localparam logic MODE_LUCAS = 1'b1;

  localparam logic [1:0] FIB_SEED_M   = 2'd0;
  localparam logic [1:0] FIB_SEED_N   = 2'd1;
  localparam logic [1:0] LUCAS_SEED_M = 2'd2;
  localparam logic [1:0] LUCAS_SEED_N = 2'd1;

  function automatic logic [1:0] seed_m(input logic mode);
    case (mode)
      MODE_FIB:   return FIB_SEED_M;
      MODE_LUCAS: return LUCAS_SEED_M;
      default:    return FIB_SEED_M;
    endcase
  endfunction

  function automatic logic [1:0] seed_n(input logic mode);
    case (mode)
      MODE_FIB:   return FIB_SEED_N;
      MODE_LUCAS: return LUCAS_SEED_N;
      default:    return FIB_SEED_N;
    endcase
  endfunction

endpackage

// File: rtl/fib_seq_gen_if.sv
// Control and result bundle of fib_seq_gen; master drives start/mode/selector,
// slave (the generator) returns the registered terms and flags.
interface fib_seq_gen_if #(
  parameter int WIDTH = 11
);
  logic             start;
  logic             mode;
  logic             selector;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] x;
  logic             done;
  logic             ovf;

  modport master (
    output start, mode, selector,
    input  m, n, x, done, ovf
  );

  modport slave (
    input  start, mode, selector,
    output m, n, x, done, ovf
  );
endinterface

// File: rtl/fib_step_add.sv
// Combinational WIDTH-bit adder for one recurrence step; with FIB_SAT_EN defined
// the sum clamps to all-ones on carry, otherwise it wraps.
module fib_step_add
  import fib_pkg::*;
#(
  parameter int WIDTH = 11
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0] full_s;

  assign full_s = {1'b0, a} + {1'b0, b};
  assign carry  = full_s[WIDTH];

  // Select the wrapped or saturated result.
  always_comb begin
    sum = full_s[WIDTH-1:0];
`ifdef FIB_SAT_EN
    if (full_s[WIDTH]) begin
      sum = {WIDTH{1'b1}};
    end else begin
      sum = full_s[WIDTH-1:0];
    end
`endif
  end

endmodule

// File: rtl/fib_seq_gen.sv
// Two-term additive recurrence generator (Fibonacci/Lucas seeds) with run control.
// Optional macro FIB_SAT_EN: saturating sum and sticky overflow flag.
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int STEPS = 20
) (
  input  logic        clk,
  input  logic        rst,
  fib_seq_gen_if.slave bus
);

  localparam logic [WIDTH-1:0] STEPS_W = WIDTH'(STEPS);
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};

  fib_state_e       state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] sum_s;
  logic             carry_s;
  logic [WIDTH-1:0] seed_m_s;
  logic [WIDTH-1:0] seed_n_s;
  logic [WIDTH-1:0] x_inc_s;

  fib_step_add #(
    .WIDTH (WIDTH)
  ) u_step_add (
    .a     (m_q),
    .b     (n_q),
    .sum   (sum_s),
    .carry (carry_s)
  );

  assign seed_m_s = WIDTH'(seed_m(bus.mode));
  assign seed_n_s = WIDTH'(seed_n(bus.mode));
  assign x_inc_s  = x_q + ONE_W;

`ifndef FIB_SAT_EN
  logic unused_carry_s;
  assign unused_carry_s = carry_s;
`endif

  // Next-state and next-output logic; every register holds unless a branch updates it.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    n_d     = n_q;
    x_d     = x_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          m_d     = seed_m_s;
          n_d     = seed_n_s;
          x_d     = '0;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        // A restart outranks an advance requested in the same cycle.
        if (bus.start) begin
          state_d = RUN;
          m_d     = seed_m_s;
          n_d     = seed_n_s;
          x_d     = '0;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
        end else if (bus.selector) begin
          m_d = n_q;
          n_d = sum_s;
          x_d = x_inc_s;
`ifdef FIB_SAT_EN
          ovf_d = ovf_q | carry_s;
`else
          ovf_d = 1'b0;
`endif
          if (x_inc_s == STEPS_W) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      n_q     <= ONE_W;
      x_q     <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      n_q     <= n_d;
      x_q     <= x_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.m    = m_q;
  assign bus.n    = n_q;
  assign bus.x    = x_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Self-checking bench for fib_seq_gen: vector table, corner sequences, random vs model.
module tb_fib_seq_gen;
  import fib_pkg::*;

  localparam int W       = 11;
  localparam int STEPS_A = 20;
  localparam int STEPS_B = 5;
  localparam int MAXV    = (1 << W) - 1;
`ifdef FIB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fib_seq_gen_if #(.WIDTH(W)) bus_a ();
  fib_seq_gen_if #(.WIDTH(W)) bus_b ();

  fib_seq_gen #(.WIDTH(W), .STEPS(STEPS_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  fib_seq_gen #(.WIDTH(W), .STEPS(STEPS_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic start;
    logic mode;
    logic sel;
    int   m;
    int   n;
    int   x;
    logic done;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_a(input string name, input int em, input int en, input int ex,
                       input logic ed, input logic eo);
    chk({name, ".m"}, 32'(bus_a.m), em);
    chk({name, ".n"}, 32'(bus_a.n), en);
    chk({name, ".x"}, 32'(bus_a.x), ex);
    chk({name, ".done"}, 32'(bus_a.done), 32'(ed));
    chk({name, ".ovf"}, 32'(bus_a.ovf), 32'(eo));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic s, input logic md, input logic sl,
                              input int m, input int n, input int x);
    vec_t v;
    v.start = s; v.mode = md; v.sel = sl; v.m = m; v.n = n; v.x = x; v.done = 1'b0;
    vecs.push_back(v);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [6:0] pat;
    int         cnt;
    int         mm, mn, mx;
    logic       md, mo, running;
    logic       r, s, mode, sel;

    rst = 1'b0;
    bus_a.start = 1'b0; bus_a.mode = 1'b0; bus_a.selector = 1'b0;
    bus_b.start = 1'b0; bus_b.mode = 1'b0; bus_b.selector = 1'b0;

    // Vector table: Fibonacci run, Lucas restart with start/selector collision, reseed.
    add(1'b1, MODE_FIB, 1'b0, 0, 1, 0);
    add(1'b0, 1'b0, 1'b1, 1, 1, 1);
    add(1'b0, 1'b0, 1'b1, 1, 2, 2);
    add(1'b0, 1'b0, 1'b1, 2, 3, 3);
    add(1'b0, 1'b0, 1'b1, 3, 5, 4);
    add(1'b0, 1'b0, 1'b1, 5, 8, 5);
    add(1'b0, 1'b0, 1'b1, 8, 13, 6);
    add(1'b0, 1'b0, 1'b1, 13, 21, 7);
    add(1'b0, 1'b0, 1'b1, 21, 34, 8);
    add(1'b0, 1'b0, 1'b1, 34, 55, 9);
    add(1'b0, 1'b0, 1'b1, 55, 89, 10);
    add(1'b0, 1'b0, 1'b0, 55, 89, 10);
    add(1'b1, MODE_LUCAS, 1'b1, 2, 1, 0);
    add(1'b0, 1'b0, 1'b1, 1, 3, 1);
    add(1'b0, 1'b0, 1'b1, 3, 4, 2);
    add(1'b0, 1'b0, 1'b1, 4, 7, 3);
    add(1'b1, MODE_FIB, 1'b1, 0, 1, 0);

    tick(); tick();
    chk_a("reset", 0, 1, 0, 1'b0, 1'b0);
    chk("reset_b.n", 32'(bus_b.n), 1);
    rst = 1'b1;
    bus_a.selector = 1'b1;
    tick();
    chk_a("idle_sel_ignored", 0, 1, 0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      bus_a.start = vecs[i].start;
      bus_a.mode = vecs[i].mode;
      bus_a.selector = vecs[i].sel;
      tick();
      chk_a($sformatf("vec%0d", i), vecs[i].m, vecs[i].n, vecs[i].x, vecs[i].done, 1'b0);
    end

    // Overflow at the 17th Fibonacci advance, then run to DONE.
    bus_a.start = 1'b0; bus_a.selector = 1'b1;
    repeat (16) tick();
    chk_a("adv16", 987, 1597, 16, 1'b0, 1'b0);
    tick();
    chk_a("adv17", 1597, SAT ? MAXV : 536, 17, 1'b0, SAT);
    repeat (3) tick();
    chk_a("adv20_done", SAT ? MAXV : 621, SAT ? MAXV : 706, 20, 1'b1, SAT);
    tick();
    chk_a("done_hold", SAT ? MAXV : 621, SAT ? MAXV : 706, 20, 1'b1, SAT);
    bus_a.start = 1'b1; bus_a.mode = MODE_LUCAS;
    tick();
    chk_a("restart_from_done", 2, 1, 0, 1'b0, 1'b0);
    bus_a.start = 1'b0; bus_a.selector = 1'b0;

    // STEPS=5 instance with gated advances.
    bus_b.start = 1'b1; bus_b.mode = MODE_FIB;
    tick();
    bus_b.start = 1'b0;
    pat = 7'b1101101;
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      bus_b.selector = pat[i];
      tick();
      if (pat[i]) cnt++;
      chk($sformatf("b_x%0d", i), 32'(bus_b.x), cnt);
      chk($sformatf("b_done%0d", i), 32'(bus_b.done), (cnt == STEPS_B) ? 1 : 0);
    end
    chk("b_m", 32'(bus_b.m), 5);
    chk("b_n", 32'(bus_b.n), 8);
    repeat (2) tick();
    chk("b_hold_m", 32'(bus_b.m), 5);
    chk("b_hold_n", 32'(bus_b.n), 8);
    chk("b_hold_x", 32'(bus_b.x), 5);
    chk("b_hold_done", 32'(bus_b.done), 1);
    bus_b.selector = 1'b0;

    // Reset mid-run, then selector ignored until a new start.
    bus_a.start = 1'b1; bus_a.mode = MODE_LUCAS; bus_a.selector = 1'b1;
    tick();
    bus_a.start = 1'b0;
    repeat (4) tick();
    chk_a("pre_reset", 7, 11, 4, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_a("mid_reset", 0, 1, 0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (3) tick();
    chk_a("post_reset_idle", 0, 1, 0, 1'b0, 1'b0);

    // Random stimulus against a behavioural model.
    mm = 0; mn = 1; mx = 0; md = 1'b0; mo = 1'b0; running = 1'b0;
    for (int c = 0; c < 600; c++) begin
      r    = ($urandom_range(0, 63) != 0);
      s    = ($urandom_range(0, 39) == 0);
      mode = 1'($urandom_range(0, 1));
      sel  = ($urandom_range(0, 3) != 0);
      rst = r; bus_a.start = s; bus_a.mode = mode; bus_a.selector = sel;
      tick();
      if (!r) begin
        mm = 0; mn = 1; mx = 0; md = 1'b0; mo = 1'b0; running = 1'b0;
      end else if (s) begin
        mm = mode ? 2 : 0; mn = 1; mx = 0; md = 1'b0; mo = 1'b0; running = 1'b1;
      end else if (running && sel) begin
        int sum;
        sum = mm + mn;
        mm  = mn;
        if (sum > MAXV) begin
          if (SAT) begin
            mn = MAXV; mo = 1'b1;
          end else begin
            mn = sum - (MAXV + 1);
          end
        end else begin
          mn = sum;
        end
        mx++;
        if (mx == STEPS_A) begin
          running = 1'b0; md = 1'b1;
        end
      end
      chk_a($sformatf("rnd%0d", c), mm, mn, mx, md, mo);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fib_seq_gen.md
Name: fib_seq_gen

Overview:
- Parametrised successor to the fixed-width Fibonacci arithmetic case.
- Generates a two-term additive recurrence, Fibonacci or Lucas seeded, of configurable width and run length.
- Adds start/run/done control, per-cycle advance gating via `selector`, and optional saturation with overflow flag.
- Used as a standalone property-mining / formal target, driven by a random-stimulus bench.

Parameters:
- WIDTH, 11, bit width of `m`, `n` and `x`.
- STEPS, 20, number of advances per run before DONE; legal range 1 .. 2**WIDTH-1.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous, active-low reset; sampled on posedge clk, 0 = reset.
- start  input  1  load seeds and begin or restart a run.
- mode  input  1  seed select: 0 = Fibonacci (m=0, n=1), 1 = Lucas (m=2, n=1); sampled only when start is accepted.
- selector  input  1  advance enable while RUN: 1 = step, 0 = hold.
- m  output  WIDTH  older term.
- n  output  WIDTH  newer term.
- x  output  WIDTH  advances taken in current run.
- done  output  1  high while in DONE.
- ovf  output  1  sticky overflow flag.

Behaviour:
- All outputs are registered; no combinational input-to-output paths.
- Reset (rst==0 at posedge):
  - state = IDLE
  - m = 0, n = 1, x = 0, done = 0, ovf = 0
  - reset overrides everything, including mid-run.
- States are IDLE, RUN, DONE.
- IDLE:
  - outputs hold.
  - start=1 → load seeds per `mode`, x = 0, ovf = 0, go to RUN next cycle.
  - selector is ignored.
- RUN, start=1 (priority over selector):
  - reload seeds per `mode`, x = 0, ovf = 0, stay in RUN.
- RUN, start=0, selector=1:
  - m <= n, n <= m+n (see overflow rules), x <= x+1.
  - If x+1 == STEPS, go to DONE; done=1 in the same cycle the last step is visible.
- RUN, start=0, selector=0: all registers hold.
- DONE:
  - outputs hold; done=1.
  - start=1 → reseed, x = 0, ovf = 0, done = 0, go to RUN.
- Latency: one cycle from accepted start or advance to the updated outputs.
- Arithmetic:
  - sum is computed WIDTH+1 bits wide; the carry bit is the overflow condition.
  - m always takes the previous n unmodified.
- Without FIB_SAT_EN:
  - n takes the low WIDTH bits of the sum (modulo 2**WIDTH).
  - ovf is constant 0.
- STEPS=1: a single advance moves RUN to DONE.

Optional Feature:
- Macro: FIB_SAT_EN.
- Defined:
  - on carry, n <= 2**WIDTH-1 and ovf <= 1.
  - ovf stays set until reset or an accepted start.
  - later sums saturate the same way.
- Undefined: wrap-around as above; ovf tied to 0.

Decomposition:
- Package fib_pkg:
  - state enum (IDLE, RUN, DONE)
  - mode constants MODE_FIB=0, MODE_LUCAS=1
  - seed constants for both modes.
- One natural sub-module, fib_step_add:
  - combinational WIDTH-bit adder producing sum and carry.
  - performs the saturation under FIB_SAT_EN.

Test Plan:
- Reset then start, mode=0, selector=1 for 10 cycles (WIDTH=11) → after 10 advances m=55, n=89, x=10, done=0.
- start, mode=1, three advances → m=4, n=7, x=3.
- Fibonacci, 17 advances at WIDTH=11, STEPS=20:
  - after 16 advances: m=987, n=1597.
  - 17th advance with FIB_SAT_EN: n=2047, ovf=1.
  - 17th advance without FIB_SAT_EN: n=536, ovf=0.
- STEPS=5, selector toggling 1,0,1,1,0,1,1:
  - x increments only on the 1s.
  - done=1 with m=5, n=8, x=5.
  - further selector=1 leaves the outputs unchanged.
- start asserted mid-run with selector=1 in the same cycle → reseed wins: m=0, n=1, x=0.
- rst=0 asserted mid-run → next posedge m=0, n=1, x=0, done=0, ovf=0, state IDLE; selector is ignored until start.
